// File: rtl/lc3_exec_in_stage.sv
// -----------------------------------------------------------------------------
// lc3_exec_in_stage
//
// Input stage for the LC3 execute unit. Accepts the decode-side execute bundle
// over a valid/ready handshake, resolves both source operands from NUM_BYP
// bypass sources at the moment of capture, and buffers up to DEPTH bundles in a
// circular buffer that is presented to the execute datapath in order.
//
// Parameters
//   DATA_W   datapath width of IR, npc, operands and bypass values
//   NUM_BYP  number of bypass sources (0 = ALU, 1 = MEM by convention), >= 1
//   DEPTH    buffer entries, >= 2
//
// Ports
//   clock, reset            rising-edge clock, asynchronous active-low reset
//   flush                   synchronous discard of all buffered entries
//   in_valid / in_ready     upstream handshake (in_ready = count < DEPTH)
//   E_Control, IR, npc_in,
//   VSR1, VSR2,
//   W_Control_in,
//   Mem_Control_in          decode-side bundle fields
//   byp_sel1, byp_sel2      one-hot bypass selects (0 = use VSR1/VSR2)
//   byp_val                 packed bypass values, source i at [i*DATA_W +: DATA_W]
//   out_valid / out_ready   downstream handshake for the head entry
//   *_out, op1, op2         head entry fields and resolved operands
//   count                   occupancy
//   stall_cnt               saturating count of backpressured cycles
// -----------------------------------------------------------------------------
module lc3_exec_in_stage #(
    parameter int DATA_W  = 16,
    parameter int NUM_BYP = 2,
    parameter int DEPTH   = 2
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          flush,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [5:0]                    E_Control,
    input  logic [DATA_W-1:0]             IR,
    input  logic [DATA_W-1:0]             npc_in,
    input  logic [DATA_W-1:0]             VSR1,
    input  logic [DATA_W-1:0]             VSR2,
    input  logic [1:0]                    W_Control_in,
    input  logic                          Mem_Control_in,
    input  logic [NUM_BYP-1:0]            byp_sel1,
    input  logic [NUM_BYP-1:0]            byp_sel2,
    input  logic [NUM_BYP*DATA_W-1:0]     byp_val,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [5:0]                    E_Control_out,
    output logic [DATA_W-1:0]             IR_out,
    output logic [DATA_W-1:0]             npc_out,
    output logic [1:0]                    W_Control_out,
    output logic                          Mem_Control_out,
    output logic [DATA_W-1:0]             op1,
    output logic [DATA_W-1:0]             op2,
    output logic [$clog2(DEPTH+1)-1:0]    count,
    output logic [15:0]                   stall_cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    // Lowest set select bit wins; an all-zero select falls back to the
    // register-file value.
    function automatic logic [DATA_W-1:0] resolve_operand(
        input logic [NUM_BYP-1:0]        sel,
        input logic [NUM_BYP*DATA_W-1:0] vals,
        input logic [DATA_W-1:0]         vsr
    );
        logic [DATA_W-1:0] res;
        res = vsr;
        for (int i = NUM_BYP - 1; i >= 0; i--) begin
            if (sel[i]) res = vals[i*DATA_W +: DATA_W];
        end
        return res;
    endfunction

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    logic [5:0]        r_ectl [DEPTH];
    logic [DATA_W-1:0] r_ir   [DEPTH];
    logic [DATA_W-1:0] r_npc  [DEPTH];
    logic [1:0]        r_wctl [DEPTH];
    logic              r_mctl [DEPTH];
    logic [DATA_W-1:0] r_op1  [DEPTH];
    logic [DATA_W-1:0] r_op2  [DEPTH];

    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic [15:0]       r_stall_cnt;

    logic              w_push;
    logic              w_pop;
    logic [DATA_W-1:0] w_op1;
    logic [DATA_W-1:0] w_op2;

    // Handshake status comes from the registered count only, so in_ready never
    // depends combinationally on out_ready.
    assign in_ready  = (r_count < CNT_W'(DEPTH));
    assign out_valid = (r_count != '0);

    // A handshake in a flush cycle is discarded.
    assign w_push = in_valid && in_ready && !flush;
    assign w_pop  = out_valid && out_ready && !flush;

    assign w_op1 = resolve_operand(byp_sel1, byp_val, VSR1);
    assign w_op2 = resolve_operand(byp_sel2, byp_val, VSR2);

    // Pointer and occupancy control
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
            if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Backpressure accounting: saturates, unaffected by flush.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_stall_cnt <= '0;
        end else if (out_valid && !out_ready && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    // Entry storage; cleared on reset so the head outputs read zero.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_ectl[i] <= '0;
                r_ir[i]   <= '0;
                r_npc[i]  <= '0;
                r_wctl[i] <= '0;
                r_mctl[i] <= 1'b0;
                r_op1[i]  <= '0;
                r_op2[i]  <= '0;
            end
        end else if (w_push) begin
            r_ectl[r_wr_ptr] <= E_Control;
            r_ir[r_wr_ptr]   <= IR;
            r_npc[r_wr_ptr]  <= npc_in;
            r_wctl[r_wr_ptr] <= W_Control_in;
            r_mctl[r_wr_ptr] <= Mem_Control_in;
            r_op1[r_wr_ptr]  <= w_op1;
            r_op2[r_wr_ptr]  <= w_op2;
        end
    end

    // Head entry drives the outputs; when empty it simply holds stale data.
    assign E_Control_out   = r_ectl[r_rd_ptr];
    assign IR_out          = r_ir[r_rd_ptr];
    assign npc_out         = r_npc[r_rd_ptr];
    assign W_Control_out   = r_wctl[r_rd_ptr];
    assign Mem_Control_out = r_mctl[r_rd_ptr];
    assign op1             = r_op1[r_rd_ptr];
    assign op2             = r_op2[r_rd_ptr];
    assign count           = r_count;
    assign stall_cnt       = r_stall_cnt;

endmodule

// File: tb/tb_lc3_exec_in_stage.sv
module tb_lc3_exec_in_stage;

    logic        clock;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [5:0]  E_Control;
    logic [15:0] IR;
    logic [15:0] npc_in;
    logic [15:0] VSR1;
    logic [15:0] VSR2;
    logic [1:0]  W_Control_in;
    logic        Mem_Control_in;
    logic [1:0]  byp_sel1;
    logic [1:0]  byp_sel2;
    logic [31:0] byp_val;
    logic        out_valid;
    logic        out_ready;
    logic [5:0]  E_Control_out;
    logic [15:0] IR_out;
    logic [15:0] npc_out;
    logic [1:0]  W_Control_out;
    logic        Mem_Control_out;
    logic [15:0] op1;
    logic [15:0] op2;
    logic [1:0]  count;
    logic [15:0] stall_cnt;

    int errors = 0;
    int checks = 0;

    lc3_exec_in_stage #(.DATA_W(16), .NUM_BYP(2), .DEPTH(2)) dut (
        .clock           (clock),
        .reset           (reset),
        .flush           (flush),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .E_Control       (E_Control),
        .IR              (IR),
        .npc_in          (npc_in),
        .VSR1            (VSR1),
        .VSR2            (VSR2),
        .W_Control_in    (W_Control_in),
        .Mem_Control_in  (Mem_Control_in),
        .byp_sel1        (byp_sel1),
        .byp_sel2        (byp_sel2),
        .byp_val         (byp_val),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .E_Control_out   (E_Control_out),
        .IR_out          (IR_out),
        .npc_out         (npc_out),
        .W_Control_out   (W_Control_out),
        .Mem_Control_out (Mem_Control_out),
        .op1             (op1),
        .op2             (op2),
        .count           (count),
        .stall_cnt       (stall_cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        // Reset held with a valid bundle on the inputs
        reset          = 1'b0;
        flush          = 1'b0;
        in_valid       = 1'b1;
        out_ready      = 1'b0;
        E_Control      = 6'h2A;
        IR             = 16'h1234;
        npc_in         = 16'h3001;
        VSR1           = 16'h0001;
        VSR2           = 16'h0002;
        W_Control_in   = 2'b10;
        Mem_Control_in = 1'b1;
        byp_sel1       = 2'b00;
        byp_sel2       = 2'b00;
        byp_val        = {16'hBBBB, 16'hAAAA};
        #3;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready",  32'(in_ready),  32'd1);
        check("rst_count",     32'(count),     32'd0);
        check("rst_stall",     32'(stall_cnt), 32'd0);
        check("rst_ir_out",    32'(IR_out),    32'd0);
        check("rst_op1",       32'(op1),       32'd0);
        tick();
        check("rst_hold_count", 32'(count), 32'd0);

        // Release and push first bundle
        reset = 1'b1;
        tick();
        check("push_out_valid", 32'(out_valid),       32'd1);
        check("push_ir",        32'(IR_out),          32'h1234);
        check("push_ectl",      32'(E_Control_out),   32'h2A);
        check("push_npc",       32'(npc_out),         32'h3001);
        check("push_wctl",      32'(W_Control_out),   32'd2);
        check("push_mctl",      32'(Mem_Control_out), 32'd1);
        check("push_op1",       32'(op1),             32'h0001);
        check("push_op2",       32'(op2),             32'h0002);
        check("push_count",     32'(count),           32'd1);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        check("pop_out_valid", 32'(out_valid), 32'd0);
        check("pop_count",     32'(count),     32'd0);
        check("pop_stall",     32'(stall_cnt), 32'd0);

        // Bypass resolution
        in_valid = 1'b1;
        IR       = 16'h2001;
        byp_sel1 = 2'b11;
        byp_sel2 = 2'b10;
        tick();
        check("byp_op1_lowest", 32'(op1), 32'hAAAA);
        check("byp_op2_src1",   32'(op2), 32'hBBBB);
        IR       = 16'h2002;
        byp_sel1 = 2'b00;
        byp_sel2 = 2'b00;
        tick();
        check("byp_none_ir",  32'(IR_out), 32'h2002);
        check("byp_none_op1", 32'(op1),    32'h0001);
        check("byp_none_op2", 32'(op2),    32'h0002);
        check("byp_none_cnt", 32'(count),  32'd1);
        IR       = 16'h2003;
        byp_sel1 = 2'b10;
        byp_sel2 = 2'b01;
        tick();
        check("byp_swap_op1", 32'(op1), 32'hBBBB);
        check("byp_swap_op2", 32'(op2), 32'hAAAA);
        byp_sel1 = 2'b00;
        byp_sel2 = 2'b00;
        in_valid = 1'b0;
        tick();
        check("byp_drain_cnt", 32'(count), 32'd0);

        // Fill and backpressure
        out_ready = 1'b0;
        in_valid  = 1'b1;
        IR        = 16'h3001;
        tick();
        check("fill1_cnt",   32'(count),     32'd1);
        check("fill1_ready", 32'(in_ready),  32'd1);
        check("fill1_stall", 32'(stall_cnt), 32'd0);
        IR = 16'h3002;
        tick();
        check("fill2_cnt",   32'(count),     32'd2);
        check("fill2_ready", 32'(in_ready),  32'd0);
        check("fill2_stall", 32'(stall_cnt), 32'd1);
        IR = 16'h3003;
        tick();
        check("fill3_cnt",   32'(count),     32'd2);
        check("fill3_head",  32'(IR_out),    32'h3001);
        check("fill3_stall", 32'(stall_cnt), 32'd2);
        tick();
        check("fill4_stall", 32'(stall_cnt), 32'd3);
        out_ready = 1'b1;
        tick();
        check("drain1_cnt",   32'(count),     32'd1);
        check("drain1_head",  32'(IR_out),    32'h3002);
        check("drain1_stall", 32'(stall_cnt), 32'd3);
        tick();
        check("drain2_cnt",  32'(count),  32'd1);
        check("drain2_head", 32'(IR_out), 32'h3003);
        in_valid = 1'b0;
        tick();
        check("drain3_cnt",   32'(count),     32'd0);
        check("drain3_valid", 32'(out_valid), 32'd0);

        // Simultaneous push/pop at count = 1 with pointer wrap
        out_ready = 1'b0;
        in_valid  = 1'b1;
        IR        = 16'h4000;
        tick();
        check("pp_prime_cnt", 32'(count), 32'd1);
        out_ready = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            IR = 16'h4000 + 16'(k);
            tick();
            check("pp_cnt",  32'(count),  32'd1);
            check("pp_head", 32'(IR_out), 32'(16'h4000 + 16'(k)));
        end
        in_valid = 1'b0;
        tick();
        check("pp_drain_cnt", 32'(count), 32'd0);

        // Flush when full
        out_ready = 1'b0;
        in_valid  = 1'b1;
        IR        = 16'h5001;
        tick();
        IR = 16'h5002;
        tick();
        check("fl_full_cnt", 32'(count), 32'd2);
        flush = 1'b1;
        IR    = 16'h5003;
        tick();
        check("fl_cnt",   32'(count),     32'd0);
        check("fl_valid", 32'(out_valid), 32'd0);
        check("fl_ready", 32'(in_ready),  32'd1);
        check("fl_stall", 32'(stall_cnt), 32'd5);
        flush    = 1'b0;
        in_valid = 1'b0;
        tick();
        check("fl_idle_cnt", 32'(count), 32'd0);

        // Flush with a concurrent push and pop
        in_valid = 1'b1;
        IR       = 16'h5101;
        tick();
        flush     = 1'b1;
        out_ready = 1'b1;
        IR        = 16'h5102;
        tick();
        check("flp_cnt",   32'(count),     32'd0);
        check("flp_valid", 32'(out_valid), 32'd0);
        flush = 1'b0;
        IR    = 16'h5103;
        tick();
        check("flp_next_cnt",  32'(count),     32'd1);
        check("flp_next_head", 32'(IR_out),    32'h5103);
        check("flp_stall",     32'(stall_cnt), 32'd5);

        // Stall counter saturation
        in_valid  = 1'b0;
        out_ready = 1'b0;
        repeat (70000) @(posedge clock);
        #1;
        check("sat_stall", 32'(stall_cnt), 32'hFFFF);
        check("sat_valid", 32'(out_valid), 32'd1);
        repeat (3) tick();
        check("sat_hold", 32'(stall_cnt), 32'hFFFF);
        check("sat_head", 32'(IR_out),    32'h5103);

        // Asynchronous reset mid-operation
        #2;
        reset = 1'b0;
        #1;
        check("amid_cnt",   32'(count),     32'd0);
        check("amid_valid", 32'(out_valid), 32'd0);
        check("amid_ready", 32'(in_ready),  32'd1);
        check("amid_stall", 32'(stall_cnt), 32'd0);
        check("amid_ir",    32'(IR_out),    32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lc3_exec_in_stage.md
# lc3_exec_in_stage

Parametrised input stage for the LC3 execute unit. Accepts the decode-side execute bundle over a valid/ready handshake and resolves both source operands from N bypass sources at capture. Buffers up to DEPTH bundles and presents them to the execute datapath in order. Generalises the fixed two-source, single-entry execute input bundle with configurable width, bypass count, buffering depth, flush and stall accounting.

## Interface
- DATA_W, 16, datapath width of IR, npc, operands and bypass values
- NUM_BYP, 2, number of bypass sources (index 0 = ALU, 1 = MEM by convention); ≥1
- DEPTH, 2, buffer entries; ≥2
- clock  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-low reset
- flush  in  1  synchronous discard of all buffered entries
- in_valid  in  1  upstream bundle valid
- in_ready  out  1  stage can accept: count < DEPTH
- E_Control  in  6  execute control
- IR  in  DATA_W  instruction
- npc_in  in  DATA_W  next PC
- VSR1, VSR2  in  DATA_W each  register-file operand values
- W_Control_in  in  2  writeback control
- Mem_Control_in  in  1  memory control
- byp_sel1, byp_sel2  in  NUM_BYP each  one-hot bypass select for operand 1/2; 0 = use VSR
- byp_val  in  NUM_BYP*DATA_W  bypass values, source i in bits [i*DATA_W +: DATA_W]
- out_valid  out  1  head entry valid
- out_ready  in  1  execute accepts head
- E_Control_out, IR_out, npc_out, W_Control_out, Mem_Control_out  out  6/DATA_W/DATA_W/2/1  head fields
- op1, op2  out  DATA_W each  resolved operands of head
- count  out  $clog2(DEPTH+1)  occupancy
- stall_cnt  out  16  saturating count of backpressured cycles

## Operation
- Push when in_valid && in_ready; pop when out_valid && out_ready. Circular buffer, write/read pointers wrap at DEPTH-1 → 0.
- Operand resolution at push: op1 = byp_val[i] for lowest set bit i of byp_sel1, else VSR1; same for op2 with byp_sel2/VSR2. Multiple set bits: lowest index wins; no error.
- Resolved operands and all control fields stored; outputs driven from head entry registers, not from inputs.
- out_valid = (count != 0). in_ready = (count < DEPTH), from registered count only; no dependence on out_ready.
- Push and pop same cycle: count unchanged, both pointers advance. At full, in_ready = 0 so no push even if popping that cycle.
- flush: pointers and count → 0 next edge; a push or pop in the flush cycle is discarded; stall_cnt not affected.
- stall_cnt increments each cycle out_valid && !out_ready; holds at 0xFFFF; cleared only by reset.
- Output fields when out_valid = 0: hold last head value (don't-care for consumers).

## Timing
- Reset (reset = 0, asynchronous): count = 0, pointers = 0, out_valid = 0, in_ready = 1, stall_cnt = 0, all data outputs = 0. Release synchronous to clock; first push accepted on first edge after release.
- Latency: bundle pushed at edge N appears at outputs with out_valid = 1 after edge N when buffer was empty (1 cycle).
- Throughput: one bundle per cycle sustained while out_ready = 1.
- Reset mid-operation: all entries lost, outputs return to reset values immediately.
- in_valid dropped without handshake: no state change; producer may change payload freely.

## Test plan
- Reset: hold reset = 0 with in_valid = 1 → out_valid = 0, in_ready = 1, count = 0, stall_cnt = 0; release, push IR = 0x1234 → next cycle IR_out = 0x1234, out_valid = 1.
- Bypass: VSR1 = 0x0001, byp_val = {0xBBBB, 0xAAAA}, byp_sel1 = 2'b11, byp_sel2 = 2'b10 → op1 = 0xAAAA, op2 = 0xBBBB; byp_sel = 0 → op1 = 0x0001.
- Fill/backpressure: out_ready = 0, push 3 bundles with DEPTH = 2 → third held, in_ready = 0 after 2, count = 2, stall_cnt counts cycles; release out_ready → bundles pop in order, third then accepted.
- Simultaneous push/pop at count = 1 for 10 cycles → count stays 1, order preserved, pointer wrap exercised.
- Flush with count = 2 and concurrent push → count = 0, out_valid = 0 next cycle, pushed bundle never appears.
- Saturation: out_ready = 0 with out_valid = 1 for 70000 cycles → stall_cnt = 0xFFFF, no wrap.
